// File: rtl/bcd_segment_counter.sv
// rtl/bcd_segment_counter.sv - four-digit BCD up/down counter with prescaler and 7-segment encoders (option: LEADING_ZERO_BLANK_EN)
module bcd_segment_counter #(
    parameter int TICK_DIV = 1000000,
    parameter int TICK_W   = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        up,
    input  logic        step,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic [6:0]  digit_0,
    output logic [6:0]  digit_1,
    output logic [6:0]  digit_2,
    output logic [6:0]  digit_3,
    output logic        wrap
);

    logic [TICK_W-1:0] prescaler;
    logic              tick;
    logic              ev;
    logic [15:0]       bcd_next;
    logic              wrap_next;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign tick = run && (prescaler == TICK_W'(TICK_DIV - 1));
    assign ev   = (run && tick) || (!run && step);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prescaler <= '0;
        end else if (run) begin
            if (tick) prescaler <= '0;
            else      prescaler <= prescaler + 1'b1;
        end
    end

    // Per-nibble decimal ripple; the final carry/borrow out is the wrap condition.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        bcd_next = bcd;
        carry    = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = bcd[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (nib == 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap_next = carry;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bcd  <= 16'h0000;
            wrap <= 1'b0;
        end else if (ev) begin
            bcd  <= bcd_next;
            wrap <= wrap_next;
        end else begin
            wrap <= 1'b0;
        end
    end

    logic blank_1, blank_2, blank_3;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_3 = (bcd[15:12] == 4'd0);
    assign blank_2 = blank_3 && (bcd[11:8] == 4'd0);
    assign blank_1 = blank_2 && (bcd[7:4] == 4'd0);
`else
    assign blank_3 = 1'b0;
    assign blank_2 = 1'b0;
    assign blank_1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_0 <= 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
            digit_1 <= 7'h00;
            digit_2 <= 7'h00;
            digit_3 <= 7'h00;
`else
            digit_1 <= 7'h3F;
            digit_2 <= 7'h3F;
            digit_3 <= 7'h3F;
`endif
        end else begin
            digit_0 <= seg7(bcd[3:0]);
            digit_1 <= blank_1 ? 7'h00 : seg7(bcd[7:4]);
            digit_2 <= blank_2 ? 7'h00 : seg7(bcd[11:8]);
            digit_3 <= blank_3 ? 7'h00 : seg7(bcd[15:12]);
        end
    end

endmodule
